// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//
// Purpose:
//   Bundles the two handshake sides of the instruction encoder into one
//   interface. The input side carries a symbolic instruction (mnemonic plus
//   operand fields) with a valid/ready handshake. The output side carries the
//   packed 32-bit word and its byte address with a second valid/ready
//   handshake. Two status flags (err_o, full_o) ride along.
//
// Signals (suffixes are from the encoder's point of view):
//   in_valid_i   symbolic instruction present
//   in_ready_o   encoder can accept an instruction this cycle
//   mnem_i       mnemonic code (0-11 valid, 12-15 invalid)
//   rs_i/rt_i/rd_i/shamt_i/funct_i/imm_i/target_i   operand fields
//   out_valid_o  FIFO head valid
//   out_ready_i  consumer takes the head this cycle
//   instr_o      encoded word at the FIFO head
//   addr_o       byte address of instr_o
//   err_o        one-cycle pulse after an invalid mnemonic is accepted
//   full_o       DEPTH words accepted, no further input taken
//
// Modports:
//   slave   the encoder itself
//   master  the program loader / testbench that drives and consumes it
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);

  logic              in_valid_i;
  logic              in_ready_o;
  logic [3:0]        mnem_i;
  logic [4:0]        rs_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic [4:0]        shamt_i;
  logic [5:0]        funct_i;
  logic [15:0]       imm_i;
  logic [25:0]       target_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [31:0]       instr_o;
  logic [ADDR_W-1:0] addr_o;
  logic              err_o;
  logic              full_o;

  // The encoder consumes symbolic instructions and produces encoded words.
  modport slave (
    input  in_valid_i,
    output in_ready_o,
    input  mnem_i,
    input  rs_i,
    input  rt_i,
    input  rd_i,
    input  shamt_i,
    input  funct_i,
    input  imm_i,
    input  target_i,
    output out_valid_o,
    input  out_ready_i,
    output instr_o,
    output addr_o,
    output err_o,
    output full_o
  );

  // The loader side drives instructions in and drains words out.
  modport master (
    output in_valid_i,
    input  in_ready_o,
    output mnem_i,
    output rs_i,
    output rt_i,
    output rd_i,
    output shamt_i,
    output funct_i,
    output imm_i,
    output target_i,
    input  out_valid_o,
    output out_ready_i,
    input  instr_o,
    input  addr_o,
    input  err_o,
    input  full_o
  );

endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// Purpose:
//   Inverse of the CPU control decoder. Takes a symbolic instruction
//   (mnemonic code plus operand fields) and packs it into a 32-bit MIPS
//   instruction word. Every encoded word is tagged with its byte address and
//   streamed out through a 2-entry FIFO. Used in the program-loader path that
//   fills instruction memory before the CPU leaves reset.
//
// Parameters:
//   DEPTH      number of words emitted before the block locks in FULL
//   ADDR_W     width of the byte address
//   BASE_ADDR  byte address given to the first emitted word
//
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   synchronous active-high reset, highest priority
//   bus     instr_encoder_if.slave carrying both handshakes and status flags
// ----------------------------------------------------------------------------
module instr_encoder #(
  parameter int                DEPTH     = 256,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  instr_encoder_if.slave  bus
);

  // Mnemonic codes presented on mnem_i.
  localparam logic [3:0] MN_RTYPE = 4'd0;
  localparam logic [3:0] MN_ADDI  = 4'd1;
  localparam logic [3:0] MN_BEQ   = 4'd2;
  localparam logic [3:0] MN_ORI   = 4'd3;
  localparam logic [3:0] MN_LW    = 4'd4;
  localparam logic [3:0] MN_SW    = 4'd5;
  localparam logic [3:0] MN_J     = 4'd6;
  localparam logic [3:0] MN_BGT   = 4'd7;
  localparam logic [3:0] MN_BNEZ  = 4'd8;
  localparam logic [3:0] MN_BGEZ  = 4'd9;
  localparam logic [3:0] MN_LUI   = 4'd10;
  localparam logic [3:0] MN_JAL   = 4'd11;

  // Primary opcodes of the instruction set the CPU decodes.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BGT   = 6'b000111;
  localparam logic [5:0] OP_BNEZ  = 6'b000101;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // The accepted-word counter must be able to hold DEPTH itself.
  localparam int                CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {
    ST_RUN,
    ST_FULL
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  acc_cnt;
  logic [ADDR_W-1:0] next_addr;

  // Two-slot FIFO kept as a shift structure: slot 0 is always the head, so
  // its registers drive instr_o/addr_o directly and simply hold when empty.
  logic [1:0]        fifo_cnt;
  logic [1:0]        fifo_cnt_nxt;
  logic [31:0]       head_word;
  logic [ADDR_W-1:0] head_addr;
  logic [31:0]       tail_word;
  logic [ADDR_W-1:0] tail_addr;

  logic              out_valid_q;
  logic              err_q;
  logic              full_q;

  logic [31:0]       enc_word;
  logic              enc_valid;
  logic              in_ready;
  logic              accept;
  logic              push;
  logic              pop;

  // Ready depends only on registered state so a consumer stalling on
  // out_ready_i can never create a combinational loop back to the producer.
  assign in_ready = (state == ST_RUN) && (fifo_cnt < 2'd2);
  assign accept   = bus.in_valid_i && in_ready;
  assign push     = accept && enc_valid;
  assign pop      = out_valid_q && bus.out_ready_i;

  // Pack the symbolic instruction into its binary format. Fields a format does
  // not use are dropped entirely; BGEZ carries its fixed rt code of 00001 and
  // BNEZ/LUI carry zero in the register slot they do not use. Mnemonics 12-15
  // leave enc_valid low so the accept completes without a push.
  always_comb begin
    enc_word  = '0;
    enc_valid = 1'b1;
    case (bus.mnem_i)
      MN_RTYPE: enc_word = {OP_RTYPE, bus.rs_i, bus.rt_i, bus.rd_i,
                            bus.shamt_i, bus.funct_i};
      MN_ADDI:  enc_word = {OP_ADDI, bus.rs_i, bus.rt_i, bus.imm_i};
      MN_BEQ:   enc_word = {OP_BEQ,  bus.rs_i, bus.rt_i, bus.imm_i};
      MN_ORI:   enc_word = {OP_ORI,  bus.rs_i, bus.rt_i, bus.imm_i};
      MN_LW:    enc_word = {OP_LW,   bus.rs_i, bus.rt_i, bus.imm_i};
      MN_SW:    enc_word = {OP_SW,   bus.rs_i, bus.rt_i, bus.imm_i};
      MN_BGT:   enc_word = {OP_BGT,  bus.rs_i, bus.rt_i, bus.imm_i};
      MN_BNEZ:  enc_word = {OP_BNEZ, bus.rs_i, 5'b00000, bus.imm_i};
      MN_BGEZ:  enc_word = {OP_BGEZ, bus.rs_i, 5'b00001, bus.imm_i};
      MN_LUI:   enc_word = {OP_LUI,  5'b00000, bus.rt_i, bus.imm_i};
      MN_J:     enc_word = {OP_J,    bus.target_i};
      MN_JAL:   enc_word = {OP_JAL,  bus.target_i};
      default:  enc_valid = 1'b0;
    endcase
  end

  // Occupancy after this cycle's push/pop. A simultaneous push and pop leaves
  // the count unchanged; a push at count 2 cannot happen since ready is low.
  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + 2'd1;
      2'b01:   fifo_cnt_nxt = fifo_cnt - 2'd1;
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // Main sequential block: RUN/FULL state machine, address and accept
  // counters, FIFO slot movement and the registered status outputs. Reset
  // wins over any handshake in flight and returns everything to idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_RUN;
      acc_cnt     <= '0;
      next_addr   <= BASE_ADDR;
      fifo_cnt    <= 2'd0;
      head_word   <= '0;
      head_addr   <= '0;
      tail_word   <= '0;
      tail_addr   <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      full_q      <= 1'b0;
    end else begin
      err_q       <= accept && !enc_valid;
      fifo_cnt    <= fifo_cnt_nxt;
      out_valid_q <= (fifo_cnt_nxt != 2'd0);

      // Only valid accepts consume an address and count toward DEPTH; the
      // address wraps naturally at the register width.
      if (push) begin
        next_addr <= next_addr + ADDR_W'(4);
        acc_cnt   <= acc_cnt + CNT_W'(1);
        if (acc_cnt == LAST_CNT) begin
          state  <= ST_FULL;
          full_q <= 1'b1;
        end
      end

      // Slot movement. When a push and pop coincide at count 1 the new word
      // lands straight in the head; a lone pop at count 2 shifts the tail up.
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            head_word <= enc_word;
            head_addr <= next_addr;
          end else begin
            tail_word <= enc_word;
            tail_addr <= next_addr;
          end
        end
        2'b01: begin
          if (fifo_cnt == 2'd2) begin
            head_word <= tail_word;
            head_addr <= tail_addr;
          end
        end
        2'b11: begin
          head_word <= enc_word;
          head_addr <= next_addr;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.instr_o     = head_word;
  assign bus.addr_o      = head_addr;
  assign bus.err_o       = err_q;
  assign bus.full_o      = full_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//
// Purpose:
//   Self-checking bench for instr_encoder. A driver issues directed and random
//   symbolic instructions; a table-driven reference model predicts each
//   encoded word and address and queues it. A separate monitor compares the
//   FIFO head, status flags and handshake against that queue every cycle.
//   DEPTH is kept small so the FULL lock-out is reached often.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h0000_1000;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  logic clk;
  logic rst;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus_if ();

  instr_encoder #(
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .BASE_ADDR (BASE)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Opcode and format per mnemonic. Format: 0 R, 1 {rs,rt,imm},
  // 2 {rs,0,imm}, 3 {rs,1,imm}, 4 {0,rt,imm}, 5 {target}.
  int op_tab[12]  = '{0, 8, 4, 13, 35, 43, 2, 7, 5, 1, 15, 3};
  int fmt_tab[12] = '{0, 1, 1, 1, 1, 1, 5, 1, 2, 3, 4, 5};

  exp_t        exp_q[$];
  int          checks_total  = 0;
  int          checks_passed = 0;
  bit          started       = 0;
  bit          push_now      = 0;
  bit          err_next      = 0;
  bit          exp_err       = 0;
  bit          exp_full      = 0;
  bit          exp_ready     = 0;
  int          acc_count     = 0;
  logic [31:0] model_addr    = BASE;
  logic [31:0] last_word     = '0;
  logic [31:0] last_addr     = '0;

  function automatic logic [31:0] ref_encode(input int m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    logic [31:0] w;
    w = 32'(op_tab[m]) * 32'h0400_0000;
    case (fmt_tab[m])
      0: w = w + 32'(rs) * 2097152 + 32'(rt) * 65536 + 32'(rd) * 2048
               + 32'(sh) * 64 + 32'(fn);
      1: w = w + 32'(rs) * 2097152 + 32'(rt) * 65536 + 32'(imm);
      2: w = w + 32'(rs) * 2097152 + 32'(imm);
      3: w = w + 32'(rs) * 2097152 + 32'd65536 + 32'(imm);
      4: w = w + 32'(rt) * 65536 + 32'(imm);
      default: w = w + 32'(tgt);
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)",
                  name, actual, expected, $time);
  endtask

  // Drive one cycle of inputs (called just after a rising edge), update the
  // reference model for what the coming edge should do, then advance.
  task automatic applyStimulus(input bit r, input bit v, input logic [3:0] m,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
      input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
      input logic [25:0] tgt, input bit ordy);
    exp_t e;
    rst                = r;
    bus_if.in_valid_i  = v;
    bus_if.mnem_i      = m;
    bus_if.rs_i        = rs;
    bus_if.rt_i        = rt;
    bus_if.rd_i        = rd;
    bus_if.shamt_i     = sh;
    bus_if.funct_i     = fn;
    bus_if.imm_i       = imm;
    bus_if.target_i    = tgt;
    bus_if.out_ready_i = ordy;
    push_now = 0;
    err_next = 0;
    if (r) begin
      exp_q.delete();
      acc_count  = 0;
      model_addr = BASE;
      last_word  = '0;
      last_addr  = '0;
    end else if (v && exp_ready) begin
      if (m < 12) begin
        e.word = ref_encode(int'(m), rs, rt, rd, sh, fn, imm, tgt);
        e.addr = model_addr;
        exp_q.push_back(e);
        model_addr = model_addr + 4;
        acc_count++;
        push_now = 1;
      end else begin
        err_next = 1;
      end
    end
    @(posedge clk);
    #1;
    push_now  = 0;
    exp_err   = err_next;
    exp_full  = (acc_count >= DEPTH);
    exp_ready = !exp_full && (exp_q.size() < 2);
    if (r) started = 1;
  endtask

  task automatic idle(input bit ordy);
    applyStimulus(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic sendI(input logic [3:0] m, input logic [4:0] rs,
      input logic [4:0] rt, input logic [15:0] imm, input bit ordy);
    applyStimulus(0, 1, m, rs, rt, 5'd9, 5'd11, 6'h2A, imm, 26'h3FF_FFFF, ordy);
  endtask

  task automatic doReset();
    applyStimulus(1, 1, 4'd1, 5'd1, 5'd1, 0, 0, 0, 16'h1, 0, 1);
  endtask

  // Monitor: mid-cycle, compare everything the DUT presents against the
  // model, and retire the head whenever the consumer takes it.
  always @(negedge clk) begin
    int n;
    exp_t h;
    if (started && !rst) begin
      n = exp_q.size() - int'(push_now);
      checkOutput("out_valid", 64'(bus_if.out_valid_o), 64'(n > 0));
      checkOutput("in_ready",  64'(bus_if.in_ready_o),  64'(exp_ready));
      checkOutput("full",      64'(bus_if.full_o),      64'(exp_full));
      checkOutput("err",       64'(bus_if.err_o),       64'(exp_err));
      if (n > 0) begin
        h = exp_q[0];
        checkOutput("head_instr", 64'(bus_if.instr_o), 64'(h.word));
        checkOutput("head_addr",  64'(bus_if.addr_o),  64'(h.addr));
        if (bus_if.out_ready_i) begin
          void'(exp_q.pop_front());
          last_word = h.word;
          last_addr = h.addr;
        end
      end else begin
        checkOutput("hold_instr", 64'(bus_if.instr_o), 64'(last_word));
        checkOutput("hold_addr",  64'(bus_if.addr_o),  64'(last_addr));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain;
    rst = 1'b1;
    bus_if.in_valid_i  = 1'b0;
    bus_if.out_ready_i = 1'b0;
    bus_if.mnem_i      = '0;
    bus_if.rs_i        = '0;
    bus_if.rt_i        = '0;
    bus_if.rd_i        = '0;
    bus_if.shamt_i     = '0;
    bus_if.funct_i     = '0;
    bus_if.imm_i       = '0;
    bus_if.target_i    = '0;
    @(posedge clk);
    #1;

    // Reset state and first ADDI with one-cycle latency.
    doReset();
    checkOutput("rst_valid", 64'(bus_if.out_valid_o), 64'(0));
    checkOutput("rst_instr", 64'(bus_if.instr_o), 64'(0));
    checkOutput("rst_ready", 64'(bus_if.in_ready_o), 64'(1));
    sendI(4'd1, 5'd1, 5'd2, 16'h0005, 1);
    checkOutput("addi_word",  64'(bus_if.instr_o), 64'h2022_0005);
    checkOutput("addi_addr",  64'(bus_if.addr_o), 64'(BASE));
    checkOutput("addi_valid", 64'(bus_if.out_valid_o), 64'(1));
    idle(1);

    // Back-to-back ORI, J, BGEZ (rt_i must be overridden).
    doReset();
    sendI(4'd3, 5'd3, 5'd4, 16'hFFFF, 1);
    checkOutput("ori_word", 64'(bus_if.instr_o), 64'h3464_FFFF);
    applyStimulus(0, 1, 4'd6, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h000_0010, 1);
    checkOutput("j_word", 64'(bus_if.instr_o), 64'h0800_0010);
    checkOutput("j_addr", 64'(bus_if.addr_o), 64'(BASE + 4));
    sendI(4'd9, 5'd5, 5'd7, 16'h0003, 1);
    checkOutput("bgez_word", 64'(bus_if.instr_o), 64'h04A1_0003);
    checkOutput("bgez_addr", 64'(bus_if.addr_o), 64'(BASE + 8));
    idle(1);

    // Back-pressure: two accepted, third stalls until a pop frees a slot.
    doReset();
    sendI(4'd1, 5'd1, 5'd1, 16'h0001, 0);
    sendI(4'd1, 5'd2, 5'd2, 16'h0002, 0);
    checkOutput("stall_ready", 64'(bus_if.in_ready_o), 64'(0));
    sendI(4'd1, 5'd3, 5'd3, 16'h0003, 1);
    checkOutput("after_pop_ready", 64'(bus_if.in_ready_o), 64'(1));
    sendI(4'd1, 5'd3, 5'd3, 16'h0003, 0);
    for (int i = 0; i < 4; i++) idle(1);

    // Invalid mnemonic between two LWs.
    doReset();
    sendI(4'd4, 5'd2, 5'd3, 16'h0010, 1);
    checkOutput("lw0_word", 64'(bus_if.instr_o), 64'h8C43_0010);
    sendI(4'd13, 5'd2, 5'd3, 16'h0010, 1);
    checkOutput("err_pulse", 64'(bus_if.err_o), 64'(1));
    sendI(4'd4, 5'd2, 5'd4, 16'h0014, 1);
    checkOutput("err_clear", 64'(bus_if.err_o), 64'(0));
    checkOutput("lw1_word", 64'(bus_if.instr_o), 64'h8C44_0014);
    checkOutput("lw1_addr", 64'(bus_if.addr_o), 64'(BASE + 4));
    idle(1);

    // FULL lock-out after DEPTH valid accepts.
    doReset();
    for (int i = 0; i < 6; i++) begin
      sendI(4'd1, 5'(i), 5'(i), 16'(i), 1);
      if (i == 3) checkOutput("full_set", 64'(bus_if.full_o), 64'(1));
    end
    checkOutput("full_ready", 64'(bus_if.in_ready_o), 64'(0));
    for (int i = 0; i < 3; i++) idle(1);

    // Reset while the FIFO holds two entries.
    doReset();
    sendI(4'd5, 5'd1, 5'd2, 16'h0100, 0);
    sendI(4'd5, 5'd3, 5'd4, 16'h0104, 0);
    doReset();
    checkOutput("rst2_valid", 64'(bus_if.out_valid_o), 64'(0));
    checkOutput("rst2_full", 64'(bus_if.full_o), 64'(0));
    sendI(4'd2, 5'd6, 5'd7, 16'h8000, 1);
    checkOutput("rst2_addr", 64'(bus_if.addr_o), 64'(BASE));
    idle(1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        doReset();
      end else begin
        logic [3:0] m;
        m = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15))
                                        : 4'($urandom_range(0, 11));
        applyStimulus(0, $urandom_range(0, 3) != 0, m,
                      5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      6'($urandom), 16'($urandom), 26'($urandom),
                      $urandom_range(0, 2) != 0);
      end
    end

    drain = 0;
    while (exp_q.size() > 0 && drain < 10) begin
      idle(1);
      drain++;
    end
    checkOutput("drain_left", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the control decoder: takes a symbolic instruction (mnemonic code plus operand fields) and packs it into a 32-bit MIPS instruction word.
- Uses the opcode set the CPU decodes.
- Each encoded word is tagged with its byte address and streamed out through a 2-entry FIFO with valid/ready handshakes on both sides.
- Sits in the testbench/program-loader path that fills instruction memory before the CPU is released from reset.

Parameters:
- DEPTH, 256: maximum number of instruction words emitted before the block locks in FULL.
- ADDR_W, 32: width of addr_o, a byte address.
- BASE_ADDR, 0: byte address assigned to the first emitted word.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- in_valid_i  input  1  symbolic instruction present.
- in_ready_o  output  1  block can accept an instruction this cycle.
- mnem_i  input  4  0 RTYPE, 1 ADDI, 2 BEQ, 3 ORI, 4 LW, 5 SW, 6 J, 7 BGT, 8 BNEZ, 9 BGEZ, 10 LUI, 11 JAL; 12-15 invalid.
- rs_i  input  5  source register field.
- rt_i  input  5  target register field.
- rd_i  input  5  destination register field (RTYPE only).
- shamt_i  input  5  shift amount (RTYPE only).
- funct_i  input  6  function code (RTYPE only).
- imm_i  input  16  immediate / branch offset.
- target_i  input  26  jump target.
- out_valid_o  output  1  FIFO head valid.
- out_ready_i  input  1  consumer takes the head this cycle.
- instr_o  output  32  encoded word at FIFO head.
- addr_o  output  ADDR_W  byte address of instr_o.
- err_o  output  1  one-cycle pulse: an invalid mnemonic was accepted.
- full_o  output  1  DEPTH words have been accepted; no further input is taken.

Behaviour:
- Reset values: FIFO empty, out_valid_o=0, instr_o=0, addr_o=0, err_o=0, full_o=0, next-address counter=BASE_ADDR, state=RUN.
- Reset has priority over every other event and clears all state regardless of any in-flight data or handshake.
- States:
  - RUN: normal operation.
  - FULL: entered on the accept that brings the accepted-valid count to DEPTH; left only by reset.
- in_ready_o = (state==RUN) && (fifo_count<2).
  - It is a function of registered state only; it is not combinationally dependent on out_ready_i.
- Accept = in_valid_i && in_ready_o.
- Encoding (opcodes):
  - RTYPE: {000000, rs, rt, rd, shamt, funct}.
  - ADDI 001000, BEQ 000100, ORI 001101, LW 100011, SW 101011, BGT 000111: {op, rs, rt, imm}.
  - BNEZ 000101: {op, rs, 00000, imm}; rt_i is ignored.
  - BGEZ 000001: {op, rs, 00001, imm}; the rt field is forced to 00001.
  - LUI 001111: {op, 00000, rt, imm}; rs_i is ignored.
  - J 000010, JAL 000011: {op, target}.
  - Operand fields not used by a format are ignored; they are never OR-ed into the word.
- Valid accept:
  - The word and the current address counter are pushed into the FIFO.
  - The counter increments by 4.
  - The accepted-valid count increments.
- Invalid accept (mnem_i 12-15):
  - The handshake completes but nothing is pushed.
  - Address and count are unchanged.
  - err_o=1 in the following cycle only.
- Latency: a word accepted in cycle N with an empty FIFO presents on instr_o/addr_o with out_valid_o=1 in cycle N+1.
- Pop = out_valid_o && out_ready_i. The head holds stable while out_valid_o=1 and out_ready_i=0.
- Push and pop in the same cycle:
  - count unchanged, order preserved.
  - With count 1, the newly pushed word becomes the head in the next cycle.
- FIFO is full at count 2: in_ready_o=0. The following cycle's in_ready_o reflects any pop.
- FIFO is empty: out_valid_o=0 and instr_o holds its last value.
- FULL:
  - full_o=1 from the cycle after the DEPTH-th valid accept.
  - in_ready_o=0 permanently.
  - FIFO contents still drain normally.
- Address wraps modulo 2^ADDR_W; no overflow flag.

Test Plan:
- Reset, then ADDI rs=1 rt=2 imm=0x0005 with out_ready_i=1 -> next cycle instr_o=0x20220005, addr_o=0, out_valid_o=1.
- Back-to-back ORI rs=3 rt=4 imm=0xFFFF, J target=0x0000010, BGEZ rs=5 imm=0x0003 (rt_i=7), all with out_ready_i=1 -> instr_o sequence 0x3464FFFF, 0x08000010, 0x04A10003; addr_o 0, 4, 8.
- out_ready_i=0, three consecutive valid inputs -> first two accepted, in_ready_o=0 on the third. Raise out_ready_i for one cycle -> first word pops, third accepted the next cycle, order preserved.
- mnem_i=13 between two LW -> err_o pulses exactly one cycle. The LWs get addr_o 0 and 4; the invalid input produces no output.
- DEPTH=4, six valid inputs -> full_o=1 after the 4th accept, only 4 words emitted (addr 0..12), in_ready_o stays 0.
- Assert rst_i while the FIFO holds 2 entries -> next cycle out_valid_o=0, full_o=0. The next accept gets addr_o=BASE_ADDR.
